// File: rtl/servo_pwm_decoder_if.sv
// ============================================================================
// Module   : servo_pwm_decoder_if
// Purpose  : Groups the PWM input pin and the decoded duty outputs of
//            servo_pwm_decoder into a single bundle.
// Signals  : pwm_in      - raw servo PWM line (asynchronous to the clock)
//            duty_cycle  - last decoded 8-bit duty code
//            duty_valid  - one-cycle strobe, duty_cycle was just loaded
//            pulse_err   - one-cycle strobe, a pulse was rejected
//            signal_lost - level, no frame seen within the timeout window
// Modports : slave  - the decoder (samples pwm_in, drives the results)
//            master - the environment (drives pwm_in, consumes the results)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface servo_pwm_decoder_if;
   logic       pwm_in;
   logic [7:0] duty_cycle;
   logic       duty_valid;
   logic       pulse_err;
   logic       signal_lost;

   modport slave (
      input  pwm_in,
      output duty_cycle,
      output duty_valid,
      output pulse_err,
      output signal_lost
   );

   modport master (
      output pwm_in,
      input  duty_cycle,
      input  duty_valid,
      input  pulse_err,
      input  signal_lost
   );
endinterface

`default_nettype wire

// File: rtl/servo_pwm_decoder.sv
// ============================================================================
// Module   : servo_pwm_decoder
// Purpose  : Measures the high time of a servo/RC PWM frame and converts it
//            back to the 8-bit duty code of the matching generator. Pulses
//            that are too short or too long are rejected with pulse_err, and
//            signal_lost reports the absence of frames.
// Ports    : Main_clock - system clock, in_freq MHz
//            reset      - asynchronous, active-low reset
//            bus        - servo_pwm_decoder_if.slave (pwm_in in; duty_cycle,
//                         duty_valid, pulse_err, signal_lost out)
// Option   : SERVO_FAILSAFE_EN - when defined, duty_cycle is forced to
//            FAILSAFE_DUTY (with one duty_valid strobe) when the signal is
//            lost; otherwise the last decoded value is kept.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module servo_pwm_decoder #(
   parameter int in_freq       = 50,    // clock frequency, MHz
   parameter int out_freq      = 50,    // nominal frame rate, Hz
   parameter int min_us        = 1000,  // pulse width for duty 0
   parameter int max_us        = 2000,  // pulse width for full scale
   parameter int FAILSAFE_DUTY = 128    // duty forced on signal loss
) (
   input  wire logic            Main_clock,
   input  wire logic            reset,
   servo_pwm_decoder_if.slave   bus
);

   // ------------------------------------------------------------------------
   // Derived constants (integer arithmetic, elaboration time only)
   // ------------------------------------------------------------------------
   localparam int MIN_CLKS  = in_freq * min_us;
   localparam int STEP_CLKS = in_freq * (max_us - min_us) / 256;
   localparam int ERR_LO    = in_freq * min_us / 2;
   localparam int ERR_HI    = in_freq * (max_us + 500);
   localparam int TIMEOUT   = 2 * in_freq * 1000000 / out_freq;

   localparam int HCW = $clog2(ERR_HI + 1);
   localparam int TCW = $clog2(TIMEOUT + 1);
   localparam int PSW = (STEP_CLKS > 1) ? $clog2(STEP_CLKS) : 1;

   localparam logic [HCW-1:0] MIN_H     = HCW'(MIN_CLKS);
   localparam logic [HCW-1:0] ERR_LO_H  = HCW'(ERR_LO);
   localparam logic [HCW-1:0] ERR_HI_M1 = HCW'(ERR_HI - 1);
   localparam logic [PSW-1:0] STEP_LAST = PSW'(STEP_CLKS - 1);
   localparam logic [TCW-1:0] TMO_MAX   = TCW'(TIMEOUT);
   localparam logic [TCW-1:0] TMO_M1    = TCW'(TIMEOUT - 1);
   localparam logic [7:0]     FS_CODE   = 8'(FAILSAFE_DUTY);

`ifdef SERVO_FAILSAFE_EN
   localparam bit FAILSAFE = 1'b1;
`else
   localparam bit FAILSAFE = 1'b0;
`endif

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      HIGH  = 2'd2,
      EVAL  = 2'd3
   } state_t;

   // ------------------------------------------------------------------------
   // Input synchronizer and edge detector
   // ------------------------------------------------------------------------
   // The chain resets to 1 so a line that is already high when reset is
   // released never shows up as a rising edge; decoding then waits in IDLE
   // for a genuine low level.
   logic sync1;
   logic sync2;
   logic sync_d;
   logic rise;
   logic fall;

   always_ff @(posedge Main_clock or negedge reset) begin
      if (!reset) begin
         sync1  <= 1'b1;
         sync2  <= 1'b1;
         sync_d <= 1'b1;
      end else begin
         sync1  <= bus.pwm_in;
         sync2  <= sync1;
         sync_d <= sync2;
      end
   end

   // Both terms come straight from flops, so the edge strobes are glitch-free.
   assign rise = sync2 & ~sync_d;
   assign fall = ~sync2 & sync_d;

   // ------------------------------------------------------------------------
   // Decoder FSM, counters and registered outputs
   // ------------------------------------------------------------------------
   state_t         state;
   logic [HCW-1:0] hcnt;        // high time in clocks
   logic [PSW-1:0] presc;       // clocks within the current duty step
   logic [7:0]     code;        // running duty code for the current pulse
   logic [TCW-1:0] tcnt;        // clocks since the last rising edge
   logic [7:0]     duty_q;
   logic           valid_q;
   logic           err_q;
   logic           lost_q;
   logic           accept;
   logic           timeout_hit;

   assign accept = (state == EVAL) && (hcnt >= ERR_LO_H);

   // A falling edge (or an accepted pulse) in the same cycle as the timeout
   // takes priority, so signal_lost is not raised then.
   assign timeout_hit = (tcnt == TMO_M1) && !rise && !lost_q && !accept &&
                        !((state == HIGH) && fall);

   always_ff @(posedge Main_clock or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         hcnt    <= '0;
         presc   <= '0;
         code    <= '0;
         tcnt    <= '0;
         duty_q  <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         lost_q  <= 1'b1;
      end else begin
         valid_q <= 1'b0;
         err_q   <= 1'b0;

         // Frame timeout runs in every state and saturates at TIMEOUT.
         if (rise)
            tcnt <= '0;
         else if (tcnt != TMO_MAX)
            tcnt <= tcnt + 1'b1;

         case (state)
            IDLE: begin
               if (!sync2)
                  state <= ARMED;
            end

            ARMED: begin
               if (rise) begin
                  state <= HIGH;
                  hcnt  <= '0;
                  presc <= '0;
                  code  <= '0;
               end
            end

            HIGH: begin
               hcnt <= hcnt + 1'b1;
               // Steps are only counted past the zero-duty width, so the
               // code equals (high_clks - MIN_CLKS) / STEP_CLKS.
               if (hcnt >= MIN_H) begin
                  if (presc == STEP_LAST) begin
                     presc <= '0;
                     if (code != 8'hFF)
                        code <= code + 8'd1;
                  end else begin
                     presc <= presc + 1'b1;
                  end
               end
               if (fall) begin
                  state <= EVAL;
               end else if (hcnt == ERR_HI_M1) begin
                  err_q <= 1'b1;
                  state <= IDLE;
               end
            end

            EVAL: begin
               if (accept) begin
                  duty_q  <= (hcnt < MIN_H) ? 8'd0 : code;
                  valid_q <= 1'b1;
                  lost_q  <= 1'b0;
               end else begin
                  err_q <= 1'b1;
               end
               state <= ARMED;
            end

            default: state <= IDLE;
         endcase

         if (timeout_hit) begin
            lost_q <= 1'b1;
            if (FAILSAFE) begin
               duty_q  <= FS_CODE;
               valid_q <= 1'b1;
            end
         end
      end
   end

   assign bus.duty_cycle  = duty_q;
   assign bus.duty_valid  = valid_q;
   assign bus.pulse_err   = err_q;
   assign bus.signal_lost = lost_q;

endmodule

`default_nettype wire

// File: tb/tb_servo_pwm_decoder.sv
// ============================================================================
// Module   : tb_servo_pwm_decoder
// Purpose  : Directed self-checking bench for servo_pwm_decoder. The decoder
//            is scaled to a 1 MHz clock (1 clock = 1 us) with a 256..768 us
//            span so every expected value is easy to derive by hand:
//              MIN_CLKS = 256, STEP_CLKS = 2, ERR_LO = 128,
//              ERR_HI = 1268, TIMEOUT = 2*1e6/500 = 4000,
//              code = min(255, (W - 256) / 2) for a W-clock high pulse.
//            Rise-based events appear 3 clocks after the raw edge and
//            duty_valid 4 clocks after the raw fall (synchronizer + edge).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_servo_pwm_decoder;

   localparam int ERR_HI_T  = 1268;
   localparam int TIMEOUT_T = 4000;
   localparam int FS_DUTY   = 77;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   fails  = 0;

   always #5 clk = ~clk;

   servo_pwm_decoder_if bus ();

   servo_pwm_decoder #(
      .in_freq       (1),
      .out_freq      (500),
      .min_us        (256),
      .max_us        (768),
      .FAILSAFE_DUTY (FS_DUTY)
   ) dut (
      .Main_clock (clk),
      .reset      (rst_n),
      .bus        (bus)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drives one W-clock high pulse followed by a low gap and reports when
   // duty_valid / pulse_err appeared (clocks after the raw fall, -1 = never).
   task automatic drive_pulse(input int w, output int v_at, output int v_cnt,
                              output int e_at);
      bus.pwm_in = 1'b1;
      repeat (w) tick();
      bus.pwm_in = 1'b0;
      v_at = -1; v_cnt = 0; e_at = -1;
      for (int n = 1; n <= 8; n++) begin
         tick();
         if (bus.duty_valid) begin
            v_cnt++;
            if (v_at < 0) v_at = n;
         end
         if (bus.pulse_err && e_at < 0) e_at = n;
      end
      repeat (150) tick();
   endtask

   task automatic test_reset();
      int bad;
      bus.pwm_in = 1'b1;
      rst_n = 1'b0;
      repeat (5) tick();
      checks++; if (bus.duty_cycle !== 8'd0) begin fails++; $display("FAIL reset_duty: got %0d want 0", bus.duty_cycle); end
      checks++; if (bus.duty_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", bus.duty_valid); end
      checks++; if (bus.pulse_err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", bus.pulse_err); end
      checks++; if (bus.signal_lost !== 1'b1) begin fails++; $display("FAIL reset_lost: got %b want 1", bus.signal_lost); end
      // Released with the line already high: that partial pulse must be ignored.
      rst_n = 1'b1;
      bad = 0;
      repeat (300) begin tick(); if (bus.duty_valid || bus.pulse_err) bad++; end
      bus.pwm_in = 1'b0;
      repeat (30) begin tick(); if (bus.duty_valid || bus.pulse_err) bad++; end
      checks++; if (bad !== 0) begin fails++; $display("FAIL partial_ignored: got %0d strobes want 0", bad); end
      checks++; if (bus.signal_lost !== 1'b1) begin fails++; $display("FAIL partial_lost: got %b want 1", bus.signal_lost); end
      checks++; if (bus.duty_cycle !== 8'd0) begin fails++; $display("FAIL partial_duty: got %0d want 0", bus.duty_cycle); end
   endtask

   task automatic test_decode();
      int w_tab [6] = '{256, 512, 768, 515, 769, 300};
      int d_tab [6] = '{0,   128, 255, 129, 255, 22};
      int v_at, v_cnt, e_at;
      for (int i = 0; i < 6; i++) begin
         drive_pulse(w_tab[i], v_at, v_cnt, e_at);
         checks++; if (v_at !== 4) begin fails++; $display("FAIL decode_latency w=%0d: got %0d want 4", w_tab[i], v_at); end
         checks++; if (v_cnt !== 1) begin fails++; $display("FAIL decode_strobes w=%0d: got %0d want 1", w_tab[i], v_cnt); end
         checks++; if (e_at !== -1) begin fails++; $display("FAIL decode_err w=%0d: got %0d want -1", w_tab[i], e_at); end
         checks++; if (bus.duty_cycle !== 8'(d_tab[i])) begin fails++; $display("FAIL decode_duty w=%0d: got %0d want %0d", w_tab[i], bus.duty_cycle, d_tab[i]); end
         checks++; if (bus.signal_lost !== 1'b0) begin fails++; $display("FAIL decode_lost w=%0d: got %b want 0", w_tab[i], bus.signal_lost); end
      end
   endtask

   task automatic test_short_pulses();
      // width, expect accepted, duty afterwards
      int w_tab [6] = '{512, 200, 128, 515, 127, 100};
      int a_tab [6] = '{1,   1,   1,   1,   0,   0};
      int d_tab [6] = '{128, 0,   0,   129, 129, 129};
      int v_at, v_cnt, e_at;
      for (int i = 0; i < 6; i++) begin
         drive_pulse(w_tab[i], v_at, v_cnt, e_at);
         checks++; if (v_at !== (a_tab[i] ? 4 : -1)) begin fails++; $display("FAIL short_valid w=%0d: got %0d want %0d", w_tab[i], v_at, a_tab[i] ? 4 : -1); end
         checks++; if (e_at !== (a_tab[i] ? -1 : 4)) begin fails++; $display("FAIL short_err w=%0d: got %0d want %0d", w_tab[i], e_at, a_tab[i] ? -1 : 4); end
         checks++; if (bus.duty_cycle !== 8'(d_tab[i])) begin fails++; $display("FAIL short_duty w=%0d: got %0d want %0d", w_tab[i], bus.duty_cycle, d_tab[i]); end
      end
   endtask

   task automatic test_err_hi();
      int n, bad, v_at, v_cnt, e_at;
      bus.pwm_in = 1'b1;
      n = 0;
      while (!bus.pulse_err && n < 2000) begin tick(); n++; end
      checks++; if (n !== ERR_HI_T + 3) begin fails++; $display("FAIL err_hi_time: got %0d want %0d", n, ERR_HI_T + 3); end
      tick();
      checks++; if (bus.pulse_err !== 1'b0) begin fails++; $display("FAIL err_hi_strobe: got %b want 0", bus.pulse_err); end
      bad = 0;
      repeat (1700 - ERR_HI_T) begin tick(); if (bus.duty_valid || bus.pulse_err) bad++; end
      bus.pwm_in = 1'b0;
      repeat (30) begin tick(); if (bus.duty_valid || bus.pulse_err) bad++; end
      checks++; if (bad !== 0) begin fails++; $display("FAIL err_hi_tail: got %0d strobes want 0", bad); end
      drive_pulse(512, v_at, v_cnt, e_at);
      checks++; if (v_at !== 4) begin fails++; $display("FAIL err_hi_recover_valid: got %0d want 4", v_at); end
      checks++; if (bus.duty_cycle !== 8'd128) begin fails++; $display("FAIL err_hi_recover_duty: got %0d want 128", bus.duty_cycle); end
   endtask

   task automatic test_timeout();
      int n, vc, lost_at, v_at, v_cnt, e_at;
      logic lost_mid;
      bus.pwm_in = 1'b1;
      n = 0;
      repeat (512) begin tick(); n++; end
      bus.pwm_in = 1'b0;
      vc = 0; lost_at = -1; lost_mid = 1'bx;
      while (lost_at < 0 && n < TIMEOUT_T + 100) begin
         tick(); n++;
         if (n == 520) lost_mid = bus.signal_lost;
         if (n > 520 && bus.duty_valid) vc++;
         if (bus.signal_lost) lost_at = n;
      end
      checks++; if (lost_mid !== 1'b0) begin fails++; $display("FAIL timeout_pre_lost: got %b want 0", lost_mid); end
      checks++; if (lost_at !== TIMEOUT_T + 3) begin fails++; $display("FAIL timeout_time: got %0d want %0d", lost_at, TIMEOUT_T + 3); end
`ifdef SERVO_FAILSAFE_EN
      checks++; if (vc !== 1) begin fails++; $display("FAIL timeout_strobes: got %0d want 1", vc); end
      checks++; if (bus.duty_cycle !== 8'(FS_DUTY)) begin fails++; $display("FAIL timeout_duty: got %0d want %0d", bus.duty_cycle, FS_DUTY); end
`else
      checks++; if (vc !== 0) begin fails++; $display("FAIL timeout_strobes: got %0d want 0", vc); end
      checks++; if (bus.duty_cycle !== 8'd128) begin fails++; $display("FAIL timeout_duty: got %0d want 128", bus.duty_cycle); end
`endif
      repeat (20) tick();
      checks++; if (bus.signal_lost !== 1'b1) begin fails++; $display("FAIL timeout_hold: got %b want 1", bus.signal_lost); end
      checks++; if (bus.duty_valid !== 1'b0) begin fails++; $display("FAIL timeout_valid_after: got %b want 0", bus.duty_valid); end
      drive_pulse(256, v_at, v_cnt, e_at);
      checks++; if (v_at !== 4) begin fails++; $display("FAIL timeout_recover_valid: got %0d want 4", v_at); end
      checks++; if (bus.signal_lost !== 1'b0) begin fails++; $display("FAIL timeout_recover_lost: got %b want 0", bus.signal_lost); end
      checks++; if (bus.duty_cycle !== 8'd0) begin fails++; $display("FAIL timeout_recover_duty: got %0d want 0", bus.duty_cycle); end
   endtask

   task automatic test_reset_mid_pulse();
      int bad, v_at, v_cnt, e_at;
      drive_pulse(515, v_at, v_cnt, e_at);
      checks++; if (bus.duty_cycle !== 8'd129) begin fails++; $display("FAIL mid_setup_duty: got %0d want 129", bus.duty_cycle); end
      bus.pwm_in = 1'b1;
      repeat (300) tick();
      #2 rst_n = 1'b0;
      #1;
      checks++; if (bus.duty_cycle !== 8'd0) begin fails++; $display("FAIL mid_async_duty: got %0d want 0", bus.duty_cycle); end
      checks++; if (bus.signal_lost !== 1'b1) begin fails++; $display("FAIL mid_async_lost: got %b want 1", bus.signal_lost); end
      tick();
      rst_n = 1'b1;
      bad = 0;
      repeat (100) begin tick(); if (bus.duty_valid || bus.pulse_err) bad++; end
      bus.pwm_in = 1'b0;
      repeat (30) begin tick(); if (bus.duty_valid || bus.pulse_err) bad++; end
      checks++; if (bad !== 0) begin fails++; $display("FAIL mid_remainder: got %0d strobes want 0", bad); end
      drive_pulse(512, v_at, v_cnt, e_at);
      checks++; if (v_at !== 4) begin fails++; $display("FAIL mid_recover_valid: got %0d want 4", v_at); end
      checks++; if (bus.duty_cycle !== 8'd128) begin fails++; $display("FAIL mid_recover_duty: got %0d want 128", bus.duty_cycle); end
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bus.pwm_in = 1'b1;
      test_reset();
      test_decode();
      test_short_pulses();
      test_err_hi();
      test_timeout();
      test_reset_mid_pulse();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

`default_nettype wire
